mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester (IF, read-only) and the load/store requester (LS, read/write with byte mask).
- Keeps at most one transaction outstanding and routes the response back to the requester that issued it.
- LS has fixed priority, bounded by an anti-starvation counter for IF.
- Supports an IF flush on control-flow redirect (pcSrc): the in-flight fetch response is discarded.

Parameters:
- STARVE_LIMIT, 4: number of consecutive LS grants, while IF is waiting, before IF is forced to win.
- AW, 64: address width.
- DW, 64: data width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req_valid  in  1  IF fetch request
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  AW  fetch address
- if_flush  in  1  discard any accepted, not-yet-returned IF response
- if_resp_valid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  DW  fetch data
- ls_req_valid  in  1  LS request
- ls_req_ready  out  1  LS request accepted this cycle
- ls_addr  in  AW  access address
- ls_wen  in  1  1 = write, 0 = read
- ls_wdata  in  DW  write data
- ls_wmask  in  8  byte write mask
- ls_resp_valid  out  1  read data or write acknowledge, one-cycle pulse
- ls_rdata  out  DW  read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  AW  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  DW  latched write data
- mem_wmask  out  8  latched mask; 0 for IF
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DW  memory read data

Behaviour:

Reset:
- rst asserted (any time, including mid-transaction): FSM=IDLE, owner=IF, drop=0, starve_cnt=0.
- All registered outputs are 0: mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask.
- All ready and resp_valid outputs are 0.

FSM states: IDLE, REQ, RESP.

IDLE:
- Grant rule:
  - ls_req_valid && !(if_req_valid && starve_cnt==STARVE_LIMIT) -> grant LS.
  - else if_req_valid -> grant IF.
- Only the winner's req_ready=1; it is combinational from valid in IDLE, and is 0 in every other state.
- On a grant, latch addr/wen/wdata/wmask (IF: wen=0, wmask=0, wdata=0), record owner, clear drop, go to REQ.
- No request -> stay in IDLE.

REQ:
- mem_req_valid=1 with the latched fields, held stable until mem_req_ready.
- mem_req_ready=1 -> RESP; mem_req_valid drops the next cycle.

RESP:
- On mem_resp_valid, go to IDLE.
- In that same cycle, owner's resp_valid = !(owner==IF && (drop || if_flush)); owner's rdata = mem_rdata.
- Non-owner resp_valid=0. rdata outputs pass mem_rdata through; they are only meaningful while resp_valid=1.

Flush:
- if_flush in REQ or RESP with owner==IF sets drop. The transaction still completes on the memory side; the response is swallowed.
- if_flush in IDLE has no effect. It does not cancel a same-cycle IF grant.

Starvation counter:
- Increments (saturating at STARVE_LIMIT) on an LS grant while if_req_valid=1.
- Clears on an IF grant, or in any IDLE cycle with if_req_valid=0.

Timing:
- Minimum latency is 3 cycles: grant edge -> REQ -> RESP, with mem_req_ready=1 and mem_resp_valid one cycle after acceptance.
- The next grant can occur in the cycle after the response (back-to-back throughput of 1 transaction per 3 cycles).

Simultaneous events and boundaries:
- Both requesters valid at counter<LIMIT -> LS wins.
- Counter==LIMIT -> IF wins once, then the counter clears.
- Only one outstanding transaction at a time; requesters must hold valid and fields stable until ready.
- mem_resp_valid outside RESP is ignored.

Test Plan:
1. Reset mid-transaction: assert rst during REQ with mem_req_valid=1 -> mem_req_valid=0 immediately (async); after release, FSM is IDLE and no resp_valid is issued.
2. Single IF fetch: if_addr=0x80000000, memory returns rdata=0x00100073 one cycle after ready -> if_req_ready at cycle 0, mem_req_valid at cycle 1 with wmask=0, if_resp_valid pulse at cycle 2 with if_rdata=0x00100073.
3. LS write: addr=0x80001008, wdata=0xDEADBEEF, wmask=0x0F, mem_req_ready held low 3 cycles -> mem fields stay stable for all 4 REQ cycles, then exactly one ls_resp_valid pulse.
4. Contention: IF and LS both valid continuously, STARVE_LIMIT=4 -> grant order LS, LS, LS, LS, IF, LS...; starve_cnt returns to 0 after the IF grant.
5. Flush: IF transaction in RESP, if_flush pulsed one cycle before mem_resp_valid -> if_resp_valid stays 0, FSM returns to IDLE, a pending LS is granted on the next cycle.
6. Flush coinciding with the response cycle, and a stray mem_resp_valid in IDLE -> no if_resp_valid in either case, state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF and LS requesters, the arbiter and the memory port.
// The arbiter uses the slave view; the requesters and memory together form the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          if_req_valid;
  logic          if_req_ready;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_resp_valid;
  logic [DW-1:0] if_rdata;

  logic          ls_req_valid;
  logic          ls_req_ready;
  logic [AW-1:0] ls_addr;
  logic          ls_wen;
  logic [DW-1:0] ls_wdata;
  logic [7:0]    ls_wmask;
  logic          ls_resp_valid;
  logic [DW-1:0] ls_rdata;

  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wmask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_addr, if_flush,
    output if_req_ready, if_resp_valid, if_rdata,
    input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    output ls_req_ready, ls_resp_valid, ls_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output if_req_valid, if_addr, if_flush,
    input  if_req_ready, if_resp_valid, if_rdata,
    output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    input  ls_req_ready, ls_resp_valid, ls_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter of one memory port between fetch (IF) and load/store (LS); 3-cycle minimum
// latency, LS-priority with IF anti-starvation; requesters are held off (ready=0) until the port is idle.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 64,
  parameter int DW           = 64
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int            CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t        r_state;
  logic          r_owner_ls;
  logic          r_drop;
  logic [CW-1:0] r_starve_cnt;
  logic          r_mem_req_valid;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_wen;
  logic [DW-1:0] r_mem_wdata;
  logic [7:0]    r_mem_wmask;

  logic w_idle;
  logic w_resp;
  logic w_if_force;
  logic w_grant_ls;
  logic w_grant_if;
  logic w_if_flush_hit;

  // Ready is combinational from valid so a grant costs no extra cycle; held low while in reset.
  assign w_idle         = (r_state == S_IDLE) && !rst;
  assign w_resp         = (r_state == S_RESP) && bus.mem_resp_valid;
  assign w_if_force     = bus.if_req_valid && (r_starve_cnt == LIMIT_C);
  assign w_grant_ls     = w_idle && bus.ls_req_valid && !w_if_force;
  assign w_grant_if     = w_idle && bus.if_req_valid && !w_grant_ls;
  assign w_if_flush_hit = bus.if_flush && !r_owner_ls;

  assign bus.if_req_ready  = w_grant_if;
  assign bus.ls_req_ready  = w_grant_ls;
  assign bus.if_resp_valid = w_resp && !r_owner_ls && !(r_drop || bus.if_flush);
  assign bus.ls_resp_valid = w_resp && r_owner_ls;
  assign bus.if_rdata      = bus.mem_rdata;
  assign bus.ls_rdata      = bus.mem_rdata;

  assign bus.mem_req_valid = r_mem_req_valid;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wen       = r_mem_wen;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.mem_wmask     = r_mem_wmask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_owner_ls      <= 1'b0;
      r_drop          <= 1'b0;
      r_starve_cnt    <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wen       <= 1'b0;
      r_mem_wdata     <= '0;
      r_mem_wmask     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Counts only LS wins that IF actually waited through.
          if (w_grant_if || !bus.if_req_valid) begin
            r_starve_cnt <= '0;
          end else if (w_grant_ls && (r_starve_cnt != LIMIT_C)) begin
            r_starve_cnt <= r_starve_cnt + CW'(1);
          end
          if (w_grant_ls) begin
            r_mem_addr      <= bus.ls_addr;
            r_mem_wen       <= bus.ls_wen;
            r_mem_wdata     <= bus.ls_wdata;
            r_mem_wmask     <= bus.ls_wmask;
            r_owner_ls      <= 1'b1;
            r_drop          <= 1'b0;
            r_mem_req_valid <= 1'b1;
            r_state         <= S_REQ;
          end else if (w_grant_if) begin
            r_mem_addr      <= bus.if_addr;
            r_mem_wen       <= 1'b0;
            r_mem_wdata     <= '0;
            r_mem_wmask     <= '0;
            r_owner_ls      <= 1'b0;
            r_drop          <= 1'b0;
            r_mem_req_valid <= 1'b1;
            r_state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_if_flush_hit) begin
            r_drop <= 1'b1;
          end
          if (bus.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_if_flush_hit) begin
            r_drop <= 1'b1;
          end
          if (bus.mem_resp_valid) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven transactions plus hand-written reset, contention and flush sequences for mem_port_arbiter.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(64), .DW(64)) bus ();
  mem_port_arbiter #(.STARVE_LIMIT(4), .AW(64), .DW(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    logic        to_ls;
    logic [63:0] rdata;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;

  // Response monitor: every resp_valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    #2;
    if (bus.if_resp_valid === 1'b1 || bus.ls_resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {62'b0, bus.ls_resp_valid, bus.if_resp_valid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_owner", {62'b0, bus.ls_resp_valid, bus.if_resp_valid}, mon_e.to_ls ? 64'd2 : 64'd1);
        chk("resp_rdata", mon_e.to_ls ? bus.ls_rdata : bus.if_rdata, mon_e.rdata);
      end
    end
  end

  typedef struct {
    logic        if_v;
    logic        ls_v;
    logic [63:0] if_addr;
    logic [63:0] ls_addr;
    logic        ls_wen;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wmask;
    int          req_wait;
    int          resp_wait;
    logic        flush_grant;
    logic        flush_req;
    int          flush_resp;
    logic [63:0] rdata;
    logic        exp_if_rdy;
    logic        exp_ls_rdy;
    logic [63:0] exp_addr;
    logic        exp_wen;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wmask;
    logic        exp_resp;
  } vec_t;

  vec_t vt[8];

  task automatic idle_cycle();
    @(negedge clk);
    bus.if_req_valid   = 1'b0;
    bus.ls_req_valid   = 1'b0;
    bus.if_flush       = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    idle_cycle();
    @(negedge clk);
    bus.if_req_valid = v.if_v;
    bus.if_addr      = v.if_addr;
    bus.ls_req_valid = v.ls_v;
    bus.ls_addr      = v.ls_addr;
    bus.ls_wen       = v.ls_wen;
    bus.ls_wdata     = v.ls_wdata;
    bus.ls_wmask     = v.ls_wmask;
    bus.if_flush     = v.flush_grant;
    #1;
    chk({nm, "_if_rdy"}, bus.if_req_ready, v.exp_if_rdy);
    chk({nm, "_ls_rdy"}, bus.ls_req_ready, v.exp_ls_rdy);
    if (v.exp_resp) sb.push_back('{to_ls: v.exp_ls_rdy, rdata: v.rdata});
    for (int k = 0; k <= v.req_wait; k++) begin
      @(negedge clk);
      bus.if_req_valid  = 1'b0;
      bus.ls_req_valid  = 1'b0;
      bus.if_flush      = (k == 0) && v.flush_req;
      bus.mem_req_ready = (k == v.req_wait);
      #1;
      chk({nm, "_mem_vld"},   bus.mem_req_valid, 1'b1);
      chk({nm, "_mem_addr"},  bus.mem_addr,      v.exp_addr);
      chk({nm, "_mem_wen"},   bus.mem_wen,       v.exp_wen);
      chk({nm, "_mem_wdata"}, bus.mem_wdata,     v.exp_wdata);
      chk({nm, "_mem_wmask"}, bus.mem_wmask,     v.exp_wmask);
    end
    for (int k = 0; k <= v.resp_wait; k++) begin
      @(negedge clk);
      bus.mem_req_ready  = 1'b0;
      bus.if_flush       = (k == v.flush_resp);
      bus.mem_resp_valid = (k == v.resp_wait);
      bus.mem_rdata      = (k == v.resp_wait) ? v.rdata : 64'hBAD0_BAD0_BAD0_BAD0;
      #1;
      chk({nm, "_mem_vld_low"}, bus.mem_req_valid, 1'b0);
    end
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.if_flush       = 1'b0;
    #3;
    chk({nm, "_sb_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    // Fields: if_v ls_v if_addr ls_addr ls_wen ls_wdata ls_wmask req_wait resp_wait flush_grant flush_req flush_resp rdata
    //         | exp_if_rdy exp_ls_rdy exp_addr exp_wen exp_wdata exp_wmask exp_resp
    vt[0] = '{1'b1, 1'b0, 64'h8000_0000, 64'h1234, 1'b1, 64'hFFFF, 8'hFF, 0, 0, 1'b0, 1'b0, -1, 64'h0010_0073,
              1'b1, 1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h00, 1'b1};
    vt[1] = '{1'b0, 1'b1, 64'h40, 64'h8000_1008, 1'b1, 64'hDEAD_BEEF, 8'h0F, 3, 0, 1'b0, 1'b0, -1, 64'h0,
              1'b0, 1'b1, 64'h8000_1008, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b1};
    vt[2] = '{1'b0, 1'b1, 64'h0, 64'h2000, 1'b0, 64'h5555, 8'h00, 1, 2, 1'b0, 1'b0, -1, 64'h1122_3344_5566_7788,
              1'b0, 1'b1, 64'h2000, 1'b0, 64'h5555, 8'h00, 1'b1};
    vt[3] = '{1'b1, 1'b1, 64'h100, 64'h200, 1'b1, 64'hCAFE, 8'hFF, 0, 1, 1'b0, 1'b0, -1, 64'hA5A5,
              1'b0, 1'b1, 64'h200, 1'b1, 64'hCAFE, 8'hFF, 1'b1};
    vt[4] = '{1'b1, 1'b0, 64'h300, 64'h0, 1'b0, 64'h0, 8'h00, 1, 1, 1'b0, 1'b1, -1, 64'h77,
              1'b1, 1'b0, 64'h300, 1'b0, 64'h0, 8'h00, 1'b0};
    vt[5] = '{1'b1, 1'b0, 64'h400, 64'h0, 1'b0, 64'h0, 8'h00, 0, 2, 1'b0, 1'b0, 2, 64'h88,
              1'b1, 1'b0, 64'h400, 1'b0, 64'h0, 8'h00, 1'b0};
    vt[6] = '{1'b1, 1'b0, 64'h500, 64'h0, 1'b0, 64'h0, 8'h00, 0, 0, 1'b1, 1'b0, -1, 64'h99,
              1'b1, 1'b0, 64'h500, 1'b0, 64'h0, 8'h00, 1'b1};
    vt[7] = '{1'b0, 1'b1, 64'h0, 64'h600, 1'b0, 64'h1, 8'h03, 0, 1, 1'b0, 1'b0, 0, 64'hAB,
              1'b0, 1'b1, 64'h600, 1'b0, 64'h1, 8'h03, 1'b1};

    bus.if_req_valid   = 1'b0;
    bus.if_addr        = '0;
    bus.if_flush       = 1'b0;
    bus.ls_req_valid   = 1'b1;
    bus.ls_addr        = 64'h77;
    bus.ls_wen         = 1'b1;
    bus.ls_wdata       = '0;
    bus.ls_wmask       = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;

    // Reset state, with a request pending that must not be acknowledged.
    @(negedge clk);
    #1;
    chk("rst_ls_rdy",    bus.ls_req_ready,  1'b0);
    chk("rst_mem_vld",   bus.mem_req_valid, 1'b0);
    chk("rst_mem_addr",  bus.mem_addr,      64'h0);
    chk("rst_mem_wen",   bus.mem_wen,       1'b0);
    chk("rst_mem_wdata", bus.mem_wdata,     64'h0);
    chk("rst_mem_wmask", bus.mem_wmask,     64'h0);
    bus.ls_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a request.
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 64'hC00;
    #1;
    chk("mid_if_rdy", bus.if_req_ready, 1'b1);
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    #1;
    chk("mid_mem_vld", bus.mem_req_valid, 1'b1);
    chk("mid_mem_addr", bus.mem_addr, 64'hC00);
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_vld",  bus.mem_req_valid, 1'b0);
    chk("mid_rst_mem_addr", bus.mem_addr,      64'h0);
    @(negedge clk);
    rst = 1'b0;
    // A stray response while idle must be ignored.
    @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'hDEAD;
    #1;
    chk("stray_if_rdy", bus.if_req_ready, 1'b0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;

    foreach (vt[i]) run_vec(vt[i], $sformatf("v%0d", i));

    // Contention: both requesters continuously valid.
    idle_cycle();
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 64'h1000;
    bus.ls_req_valid = 1'b1;
    bus.ls_addr      = 64'h2000;
    bus.ls_wen       = 1'b0;
    bus.ls_wdata     = '0;
    bus.ls_wmask     = '0;
    for (int g = 0; g < 10; g++) begin
      logic exp_ls;
      exp_ls = ((g % 5) != 4);
      #1;
      chk($sformatf("cont%0d_ls_rdy", g), bus.ls_req_ready, exp_ls);
      chk($sformatf("cont%0d_if_rdy", g), bus.if_req_ready, !exp_ls);
      sb.push_back('{to_ls: exp_ls, rdata: 64'(g + 16)});
      @(negedge clk);
      bus.mem_req_ready = 1'b1;
      #1;
      chk($sformatf("cont%0d_addr", g), bus.mem_addr, exp_ls ? 64'h2000 : 64'h1000);
      @(negedge clk);
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 64'(g + 16);
      #1;
      chk($sformatf("cont%0d_busy_rdy", g), {bus.if_req_ready, bus.ls_req_ready}, 64'd0);
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
    end
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    #3;
    chk("cont_sb_drained", 64'(sb.size()), 64'd0);

    // Flush one cycle before the IF response with an LS request waiting.
    idle_cycle();
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 64'h3000;
    #1;
    chk("fl_if_rdy", bus.if_req_ready, 1'b1);
    @(negedge clk);
    bus.if_req_valid  = 1'b0;
    bus.ls_req_valid  = 1'b1;
    bus.ls_addr       = 64'h3100;
    bus.ls_wen        = 1'b1;
    bus.ls_wdata      = 64'h42;
    bus.ls_wmask      = 8'h01;
    bus.mem_req_ready = 1'b1;
    #1;
    chk("fl_req_ls_rdy", bus.ls_req_ready, 1'b0);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    bus.if_flush      = 1'b1;
    #1;
    chk("fl_resp_ls_rdy", bus.ls_req_ready, 1'b0);
    @(negedge clk);
    bus.if_flush       = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'hFEED;
    #1;
    chk("fl_drop_if_vld", bus.if_resp_valid, 1'b0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("fl_next_ls_rdy", bus.ls_req_ready, 1'b1);
    sb.push_back('{to_ls: 1'b1, rdata: 64'h5A});
    @(negedge clk);
    bus.ls_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    chk("fl_ls_addr",  bus.mem_addr,  64'h3100);
    chk("fl_ls_wmask", bus.mem_wmask, 64'h01);
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 64'h5A;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    #3;
    chk("fl_sb_drained", 64'(sb.size()), 64'd0);

    // Stray response in idle, then a normal fetch proves the state was untouched.
    idle_cycle();
    @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    #1;
    chk("stray2_resp", {bus.if_resp_valid, bus.ls_resp_valid}, 64'd0);
    run_vec(vt[0], "v0_again");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
